vga_pattern_gen: RTL and testbench

- Pixel-source stage directly upstream of the VGA output pins. It consumes the timing controller's pixel enable, counters and raw syncs, and produces registered 4:4:4 RGB with delay-matched hsync/vsync.
- Provides three selectable test patterns: colour bars, checkerboard and a bouncing box. A debounced push-button cycles the pattern, and the change is applied only at frame boundaries.

---
 rtl/vga_pkg.sv | 48 ++++
 rtl/btn_debounce.sv | 50 +++++
 rtl/vga_pattern_gen.sv | 174 +++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern path: display modes, palette and
// the 640x480 timing constants also used by the timing controller.
package vga_pkg;

  typedef enum logic [1:0] {
    BARS    = 2'd0,
    CHECKER = 2'd1,
    BOX     = 2'd2
  } mode_e;

  // 4:4:4 palette, {R,G,B}
  localparam logic [11:0] COL_WHITE   = 12'hFFF;
  localparam logic [11:0] COL_YELLOW  = 12'hFF0;
  localparam logic [11:0] COL_CYAN    = 12'h0FF;
  localparam logic [11:0] COL_GREEN   = 12'h0F0;
  localparam logic [11:0] COL_MAGENTA = 12'hF0F;
  localparam logic [11:0] COL_RED     = 12'hF00;
  localparam logic [11:0] COL_BLUE    = 12'h00F;
  localparam logic [11:0] COL_BLACK   = 12'h000;
  localparam logic [11:0] COL_NAVY    = 12'h002;

  // 640x480 @ 60 Hz timing, 800 x 521 total
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_BP        = 48;
  localparam int VGA_H_ACT       = 640;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_BP        = 29;
  localparam int VGA_V_ACT       = 480;
  localparam int VGA_V_TOTAL     = 521;
  localparam int VGA_H_ACT_START = VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_ACT_START = VGA_V_SYNC + VGA_V_BP;

  // Colour of one of the eight vertical bars, left to right
  function automatic logic [11:0] bar_colour(input logic [2:0] bar);
    case (bar)
      3'd0:    return COL_WHITE;
      3'd1:    return COL_YELLOW;
      3'd2:    return COL_CYAN;
      3'd3:    return COL_GREEN;
      3'd4:    return COL_MAGENTA;
      3'd5:    return COL_RED;
      3'd6:    return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// one-clk pulse when the debounced level rises.
module btn_debounce #(
  parameter int CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchroniser, debounced level and stability counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count consecutive clks of disagreement; flip the level on the last one
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    rise_o  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        cnt_d   = '0;
        rise_o  = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern source: two-stage pixel pipeline (counters -> RGB) with
// delay-matched syncs, a frame-synchronous mode FSM and a bouncing box.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACT_START     = VGA_H_ACT_START,
  parameter int V_ACT_START     = VGA_V_ACT_START,
  parameter int H_ACT           = VGA_H_ACT,
  parameter int V_ACT           = VGA_V_ACT,
  parameter int BOX_SIZE        = 32,
  parameter int BOX_STEP        = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       mode_btn,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic [1:0] mode
);

  // One axis of box motion: returns {negative_dir, new_position}, clamped
  function automatic logic [10:0] box_next(input logic [9:0] pos, input logic neg,
                                           input int lim);
    logic signed [10:0] n;
    n = neg ? ($signed({1'b0, pos}) - $signed(11'(BOX_STEP)))
            : ($signed({1'b0, pos}) + $signed(11'(BOX_STEP)));
    if (n >= $signed(11'(lim))) begin
      return {1'b1, 10'(lim)};
    end else if (n < 11'sd0) begin
      return {1'b0, 10'd0};
    end else begin
      return {neg, n[9:0]};
    end
  endfunction

  logic        btn_rise;
  logic        frame_evt;
  logic        vs_prev_q;
  logic        act1_q, act1_d;
  logic [9:0]  x1_q, y1_q;
  logic        hs1_q, vs1_q;
  logic [11:0] rgb_q, rgb_d;
  logic        hs2_q, vs2_q;
  mode_e       mode_q, mode_d;
  logic        pending_q, pending_d;
  logic [9:0]  bx_q, by_q, bx_d, by_d;
  logic        dx_q, dy_q, dx_d, dy_d;
  logic        in_box;

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk_i  (clk),
    .rst_i  (rst),
    .btn_i  (mode_btn),
    .rise_o (btn_rise)
  );

  assign frame_evt = pix_en && vs_prev_q && !vsync_in;

  // Active-region decode for the counters entering stage 1
  always_comb begin
    act1_d = (hcount >= 10'(H_ACT_START)) && (hcount < 10'(H_ACT_START + H_ACT)) &&
             (vcount >= 10'(V_ACT_START)) && (vcount < 10'(V_ACT_START + V_ACT));
  end

  // Pixel colour from stage-1 coordinates and the current mode
  always_comb begin
    in_box = ({1'b0, x1_q} >= {1'b0, bx_q}) && ({1'b0, x1_q} < ({1'b0, bx_q} + 11'(BOX_SIZE))) &&
             ({1'b0, y1_q} >= {1'b0, by_q}) && ({1'b0, y1_q} < ({1'b0, by_q} + 11'(BOX_SIZE)));
    rgb_d  = COL_BLACK;
    if (act1_q) begin
      case (mode_q)
        BARS:    rgb_d = bar_colour(3'(x1_q / 10'd80));
        CHECKER: rgb_d = (x1_q[5] ^ y1_q[5]) ? COL_WHITE : COL_BLACK;
        BOX:     rgb_d = in_box ? COL_RED : COL_NAVY;
        default: rgb_d = COL_BLACK;
      endcase
    end else begin
      rgb_d = COL_BLACK;
    end
  end

  // Mode FSM and pending flag: consume at frame event, then re-arm on a press
  always_comb begin
    mode_d    = mode_q;
    pending_d = pending_q;
    if (frame_evt) begin
      case (mode_q)
        BARS:    mode_d = pending_q ? CHECKER : BARS;
        CHECKER: mode_d = pending_q ? BOX : CHECKER;
        BOX:     mode_d = pending_q ? BARS : BOX;
        default: mode_d = BARS;
      endcase
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (btn_rise) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_d;
    end
  end

  // Box position/direction, stepped once per frame regardless of mode
  always_comb begin
    bx_d = bx_q;
    by_d = by_q;
    dx_d = dx_q;
    dy_d = dy_q;
    if (frame_evt) begin
      {dx_d, bx_d} = box_next(bx_q, dx_q, H_ACT - BOX_SIZE);
      {dy_d, by_d} = box_next(by_q, dy_q, V_ACT - BOX_SIZE);
    end else begin
      bx_d = bx_q;
      by_d = by_q;
    end
  end

  // Pipeline, frame-edge detector, mode and box state
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q <= 1'b1;
      act1_q    <= 1'b0;
      x1_q      <= 10'd0;
      y1_q      <= 10'd0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      rgb_q     <= 12'h000;
      hs2_q     <= 1'b1;
      vs2_q     <= 1'b1;
      mode_q    <= BARS;
      pending_q <= 1'b0;
      bx_q      <= 10'd0;
      by_q      <= 10'd0;
      dx_q      <= 1'b0;
      dy_q      <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (pix_en) begin
        vs_prev_q <= vsync_in;
        act1_q    <= act1_d;
        x1_q      <= hcount - 10'(H_ACT_START);
        y1_q      <= vcount - 10'(V_ACT_START);
        hs1_q     <= hsync_in;
        vs1_q     <= vsync_in;
        rgb_q     <= rgb_d;
        hs2_q     <= hs1_q;
        vs2_q     <= vs1_q;
        mode_q    <= mode_d;
        bx_q      <= bx_d;
        by_q      <= by_d;
        dx_q      <= dx_d;
        dy_q      <= dy_d;
      end
    end
  end

  assign red   = rgb_q[11:8];
  assign green = rgb_q[7:4];
  assign blue  = rgb_q[3:0];
  assign hsync = hs2_q;
  assign vsync = vs2_q;
  assign mode  = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen with a scoreboard of expected pixels.
module tb_vga_pattern_gen;

  logic       clk = 1'b0;
  logic       rst, pix_en, hsync_in, vsync_in, mode_btn;
  logic [9:0] hcount, vcount;
  logic       hsync, vsync;
  logic [3:0] red, green, blue;
  logic [1:0] mode;

  vga_pattern_gen #(.DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .mode_btn(mode_btn),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue), .mode(mode)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_bx, m_by, m_dx, m_dy, m_mode;
  bit m_pend, m_vsprev;
  logic [11:0] bars_t [0:7] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                12'hF0F, 12'hF00, 12'h00F, 12'h000};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] exp_colour(input int h, input int v);
    int x, y;
    x = h - 144;
    y = v - 31;
    if (x < 0 || x >= 640 || y < 0 || y >= 480) return 12'h000;
    if (m_mode == 0) return bars_t[x / 80];
    if (m_mode == 1) return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
    return (x >= m_bx && x < m_bx + 32 && y >= m_by && y < m_by + 32) ? 12'hF00 : 12'h002;
  endfunction

  task automatic model_frame();
    int nx, ny;
    nx = m_bx + 2 * m_dx;
    if (nx >= 608) begin nx = 608; m_dx = -1; end
    else if (nx < 0) begin nx = 0; m_dx = 1; end
    m_bx = nx;
    ny = m_by + 2 * m_dy;
    if (ny >= 448) begin ny = 448; m_dy = -1; end
    else if (ny < 0) begin ny = 0; m_dy = 1; end
    m_by = ny;
    if (m_pend) begin
      m_mode = (m_mode + 1) % 3;
      m_pend = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1; m_mode = 0;
    m_pend = 1'b0; m_vsprev = 1'b1;
    q.delete();
  endtask

  // One pixel slot: pix_en on the first of four clks
  task automatic beat(input int h, input int v, input bit hs, input bit vs);
    exp_t e;
    pix_en = 1'b1; hcount = 10'(h); vcount = 10'(v); hsync_in = hs; vsync_in = vs;
    if (m_vsprev && !vs) model_frame();
    m_vsprev = vs;
    e.rgb = exp_colour(h, v); e.hs = hs; e.vs = vs;
    q.push_back(e);
    tick();
    pix_en = 1'b0;
    if (q.size() == 2) begin
      e = q.pop_front();
      check_val("pix", 32'({red, green, blue, hsync, vsync}), 32'({e.rgb, e.hs, e.vs}));
    end
    tick(); tick(); tick();
  endtask

  task automatic frame();
    beat(0, 0, 1'b1, 1'b1);
    beat(0, 0, 1'b1, 1'b0);
  endtask

  task automatic press();
    mode_btn = 1'b1; repeat (30) tick();
    mode_btn = 1'b0; repeat (30) tick();
    m_pend = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    model_reset();
    check_val("rst_rgb", 32'({red, green, blue}), 32'd0);
    check_val("rst_syncs", 32'({hsync, vsync}), 32'd3);
    check_val("rst_mode", 32'(mode), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; pix_en = 1'b0; hcount = 10'd0; vcount = 10'd0;
    hsync_in = 1'b1; vsync_in = 1'b1; mode_btn = 1'b0;
    repeat (3) tick();
    do_reset();

    // First active pixel, left neighbour, and region edges
    beat(144, 31, 1'b0, 1'b1);
    beat(143, 31, 1'b1, 1'b1);
    beat(783, 31, 1'b0, 1'b1);
    beat(784, 31, 1'b1, 1'b1);
    beat(144, 510, 1'b1, 1'b1);
    beat(144, 511, 1'b0, 1'b1);
    beat(144, 30, 1'b1, 1'b1);
    // Colour bars with alternating hsync
    for (int k = 0; k < 8; k++) beat(144 + 80 * k, 100, k[0], 1'b1);
    beat(223, 100, 1'b1, 1'b1);

    // Bounces only: no pending, so a frame leaves mode alone
    for (int b = 0; b < 5; b++) begin
      mode_btn = 1'b1; repeat (5) tick();
      mode_btn = 1'b0; repeat (5) tick();
    end
    repeat (30) tick();
    frame();
    check_val("bounce_mode", 32'(mode), 32'(m_mode));
    // Bounces then a steady hold: one pending edge
    for (int b = 0; b < 5; b++) begin
      mode_btn = 1'b1; repeat (5) tick();
      mode_btn = 1'b0; repeat (5) tick();
    end
    press();
    check_val("held_mode", 32'(mode), 32'd0);
    beat(0, 0, 1'b1, 1'b1);
    check_val("pre_fall_mode", 32'(mode), 32'd0);
    beat(0, 0, 1'b1, 1'b0);
    check_val("fall_mode", 32'(mode), 32'd1);

    // Checkerboard
    beat(144, 31, 1'b1, 1'b1);
    beat(176, 31, 1'b1, 1'b1);
    beat(144, 63, 1'b1, 1'b1);
    beat(176, 63, 1'b1, 1'b1);
    beat(783, 510, 1'b1, 1'b1);
    beat(175, 62, 1'b1, 1'b1);

    // Two presses in one frame advance by one
    press();
    press();
    frame();
    check_val("two_press_mode", 32'(mode), 32'd2);
    frame();
    check_val("two_press_hold", 32'(mode), 32'd2);

    // Bouncing box over 400 frames
    for (int f = 0; f < 400; f++) begin
      frame();
      beat(144 + m_bx, 31 + m_by, 1'b1, 1'b1);
      beat(144 + m_bx + 31, 31 + m_by + 31, 1'b1, 1'b1);
      beat(144 + m_bx + 32, 31 + m_by, 1'b1, 1'b1);
      if (m_bx > 0) beat(144 + m_bx - 1, 31 + m_by, 1'b1, 1'b1);
    end

    // Reset mid-line in BOX mode
    beat(144 + m_bx, 31 + m_by, 1'b0, 1'b1);
    beat(144 + m_bx + 1, 31 + m_by, 1'b0, 1'b1);
    hsync_in = 1'b0; vsync_in = 1'b0;
    tick();
    do_reset();
    beat(144, 31, 1'b1, 1'b1);
    beat(145, 31, 1'b1, 1'b1);

    // Press already pending, second press lands on a frame event
    press();
    beat(0, 0, 1'b1, 1'b1);
    q.delete();
    mode_btn = 1'b1;
    repeat (17) tick();
    pix_en = 1'b1; hcount = 10'd0; vcount = 10'd0; vsync_in = 1'b0;
    model_frame();
    m_pend = 1'b1;
    m_vsprev = 1'b0;
    tick();
    pix_en = 1'b0;
    check_val("coinc_now", 32'(mode), 32'd1);
    repeat (30) tick();
    mode_btn = 1'b0;
    repeat (30) tick();
    frame();
    check_val("coinc_next", 32'(mode), 32'd2);
    frame();
    check_val("coinc_after", 32'(mode), 32'd2);
    // Box restarted from origin after reset
    beat(144 + m_bx, 31 + m_by, 1'b1, 1'b1);
    beat(144 + m_bx + 32, 31 + m_by, 1'b1, 1'b1);
    beat(144, 31, 1'b1, 1'b1);
    beat(0, 0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
